sdram_arbiter: RTL

Central sequencer for the SDRAM controller. Waits for power-up initialisation to finish, then grants the single SDRAM command/address/data bus to one of three requesters (auto-refresh, write, read) at a time. Auto-refresh always has top priority. The block muxes the winner's command, bank and address onto the device pins and owns the tri-state data bus. It sits between the `sdram_init`, `sdram_aref`, `sdram_write` and `sdram_read` sub-blocks and the SDRAM pins.

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_arbiter_if.sv | 64 ++++++
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller sub-blocks:
//   - SDRAM command encodings, as {cs_n, ras_n, cas_n, we_n}
//   - arbiter state encoding
//   - idle bank/address values driven while no requester owns the bus
// -----------------------------------------------------------------------------
package sdram_pkg;

  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP   = 4'b0110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  // Idle bus: bank 3, address all-ones (fill bit replicated to the address width).
  localparam logic [1:0] IDLE_BANK      = 2'b11;
  localparam logic       IDLE_ADDR_FILL = 1'b1;

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Requester-side bus of the SDRAM arbiter: the init, auto-refresh, write and
// read sub-blocks present their request/end handshakes and their registered
// command/bank/address buses here, and receive their grants back.
//   slave  : arbiter view (requests and buses in, grants and read data out)
//   master : requester view (the opposite directions)
// Parameters: ADDR_W (SDRAM address width), DATA_W (SDRAM data width).
// -----------------------------------------------------------------------------
interface sdram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);

  // init phase
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end;

  // auto-refresh
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_bank;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;

  // write
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              wr_en;

  // read
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_sdram_data;
  logic              rd_en;

  modport slave (
    input  init_cmd, init_bank, init_addr, init_end,
    input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output aref_en, wr_en, rd_en, rd_sdram_data
  );

  modport master (
    output init_cmd, init_bank, init_addr, init_end,
    output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  aref_en, wr_en, rd_en, rd_sdram_data
  );

endinterface

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Central sequencer of the SDRAM controller. Holds the pins on the init bus
// until init_end, then hands the single command/address/data bus to one of
// auto-refresh, write or read at a time (refresh always first, no preemption).
//
// Ports:
//   clk          100 MHz controller clock
//   rstn         asynchronous active-low reset
//   bus          requester bus (sdram_arbiter_if.slave): requests, ends,
//                per-requester cmd/bank/addr, write data, grants, read data
//   sdram_cke    clock enable, tied high
//   sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n   command pins
//   sdram_ba     bank pins
//   sdram_addr   address pins
//   sdram_dq     bidirectional data bus, driven only during a write burst
//
// Build option SDRAM_ARB_RR_EN: when defined, simultaneous write and read
// requests alternate round-robin; otherwise write beats read.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  sdram_arbiter_if.slave    bus,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  arb_state_e state, next_state;
  logic [3:0] cmd;

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;  // 1: the most recent write/read grant went to write
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_INIT;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: if (bus.init_end) next_state = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.aref_req)                  next_state = ST_AREF;
`ifdef SDRAM_ARB_RR_EN
        else if (bus.wr_req && bus.rd_req) next_state = last_wr ? ST_READ : ST_WRITE;
`endif
        else if (bus.wr_req)               next_state = ST_WRITE;
        else if (bus.rd_req)               next_state = ST_READ;
      end
      ST_AREF:  if (bus.aref_end) next_state = ST_ARBIT;
      ST_WRITE: if (bus.wr_end)   next_state = ST_ARBIT;
      ST_READ:  if (bus.rd_end)   next_state = ST_ARBIT;
      default:  next_state = ST_INIT;
    endcase
  end

  // Grants are registered copies of the next state: set on the edge that
  // enters the state, cleared on the edge that leaves it on *_end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.aref_en <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.rd_en   <= 1'b0;
    end else begin
      bus.aref_en <= (next_state == ST_AREF);
      bus.wr_en   <= (next_state == ST_WRITE);
      bus.rd_en   <= (next_state == ST_READ);
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_wr <= 1'b0;
    end else if (state == ST_ARBIT) begin
      if (next_state == ST_WRITE)     last_wr <= 1'b1;
      else if (next_state == ST_READ) last_wr <= 1'b0;
    end
  end
`endif

  // Pin mux: combinational from the registered state so each requester's
  // registered bus reaches the pins with no extra cycle.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = IDLE_BANK;
    sdram_addr = {ADDR_W{IDLE_ADDR_FILL}};
    case (state)
      ST_INIT: begin
        cmd        = bus.init_cmd;
        sdram_ba   = bus.init_bank;
        sdram_addr = bus.init_addr;
      end
      ST_AREF: begin
        cmd        = bus.aref_cmd;
        sdram_ba   = bus.aref_bank;
        sdram_addr = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd        = bus.wr_cmd;
        sdram_ba   = bus.wr_bank;
        sdram_addr = bus.wr_addr;
      end
      ST_READ: begin
        cmd        = bus.rd_cmd;
        sdram_ba   = bus.rd_bank;
        sdram_addr = bus.rd_addr;
      end
      default: ;  // ARBIT keeps the idle NOP bus
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

  // The data bus is only ever driven by the write block, and only while it
  // owns the bus; reset drops state to INIT and releases it at once.
  assign sdram_dq          = (state == ST_WRITE && bus.wr_sdram_en) ? bus.wr_sdram_data : 'z;
  assign bus.rd_sdram_data = sdram_dq;

endmodule
